uart_axil_poller: RTL

AXI-Lite master controller that configures and drains the UART receive register block. On start it writes the baud rate and control word, then polls the status register and reads each received byte when `data_ready` is set. Bytes are buffered in a small FIFO and presented on an AXI-Stream-style output. It sits between the UART register slave and the byte consumer, replacing software polling.

---
 rtl/uart_poll_pkg.sv | 23 ++
 rtl/uart_poll_fifo.sv | 50 +++++
 rtl/uart_axil_poller.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_poll_pkg.sv
// uart_poll_pkg: register map, status/control bit positions and poller state encoding
package uart_poll_pkg;

    localparam logic [3:0] ADDR_BAUD   = 4'h0;
    localparam logic [3:0] ADDR_CTRL   = 4'h4;
    localparam logic [3:0] ADDR_RXDATA = 4'h8;

    localparam int STAT_DATA_READY = 0;
    localparam int STAT_OVERRUN    = 1;
    localparam int CTRL_INTR_EN    = 8;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WR_BAUD,
        WR_CTRL,
        POLL_WAIT,
        RD_STAT,
        RD_DATA
    } poll_state_t;

endpackage

// File: rtl/uart_poll_fifo.sv
// uart_poll_fifo: small synchronous byte FIFO with wrap-bit pointers and full/empty flags
module uart_poll_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  push_ok, pop_ok;

    assign empty    = wr_ptr_q == rd_ptr_q;
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // advance each pointer on its accepted operation
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end

    // pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // storage needs no reset; the pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_axil_poller.sv
// uart_axil_poller: AXI-Lite master that configures a UART, polls status and streams received bytes (optional overrun counter: UART_POLL_OVERRUN_CNT_EN)
module uart_axil_poller
    import uart_poll_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH         = 8,
    parameter int FIFO_DEPTH         = 4,
    parameter int POLL_GAP           = 16
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            cfg_start,
    input  logic                            cfg_stop,
    input  logic [31:0]                     cfg_baud,
    input  logic                            cfg_intr_en,
    output logic                            busy,
    output logic                            resp_err,
    output logic [15:0]                     overrun_cnt,
    output logic [DATA_WIDTH-1:0]           rx_tdata,
    output logic                            rx_tvalid,
    input  logic                            rx_tready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

    poll_state_t                   state_q, state_d;
    logic                          issued_q, issued_d;
    logic                          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                          arvalid_q, arvalid_d, rready_q, rready_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d, ctrl_word;
    logic                          stop_q, stop_d, err_q, err_d;
    logic [15:0]                   gap_q, gap_d;
    logic                          b_hs, r_hs, stop_now, push, fifo_full, fifo_empty;
    logic                          unused_rdata;

    assign b_hs          = bready_q && M_AXI_BVALID;
    assign r_hs          = rready_q && M_AXI_RVALID;
    assign stop_now      = stop_q || cfg_stop;
    assign ctrl_word     = C_M_AXI_DATA_WIDTH'(cfg_intr_en) << CTRL_INTR_EN;
    assign busy          = state_q != IDLE;
    assign resp_err      = err_q;
    assign rx_tvalid     = !fifo_empty;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign unused_rdata  = ^M_AXI_RDATA[C_M_AXI_DATA_WIDTH-1:DATA_WIDTH];

    // sequencer: issue one transaction per state, advance on its B/R completion
    always_comb begin
        state_d   = state_q;
        issued_d  = issued_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        araddr_d  = araddr_q;
        stop_d    = busy && stop_now;
        err_d     = err_q || (b_hs && M_AXI_BRESP != RESP_OKAY) || (r_hs && M_AXI_RRESP != RESP_OKAY);
        gap_d     = gap_q;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start && !cfg_stop) begin
                    state_d = WR_BAUD;
                    err_d   = 1'b0;
                end
            end
            WR_BAUD, WR_CTRL: begin
                if (!issued_q) begin
                    issued_d  = 1'b1;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = state_q == WR_BAUD ? C_M_AXI_ADDR_WIDTH'(ADDR_BAUD) : C_M_AXI_ADDR_WIDTH'(ADDR_CTRL);
                    wdata_d   = state_q == WR_BAUD ? C_M_AXI_DATA_WIDTH'(cfg_baud) : ctrl_word;
                end else begin
                    awvalid_d = awvalid_q && !M_AXI_AWREADY;
                    wvalid_d  = wvalid_q && !M_AXI_WREADY;
                    bready_d  = !awvalid_d && !wvalid_d && !b_hs;
                    if (b_hs) begin
                        issued_d = 1'b0;
                        gap_d    = '0;
                        state_d  = stop_now ? IDLE : (state_q == WR_BAUD ? WR_CTRL : POLL_WAIT);
                    end
                end
            end
            POLL_WAIT: begin
                if (gap_q != GAP_LAST) gap_d = gap_q + 16'd1;
                else if (!fifo_full) state_d = RD_STAT;
            end
            default: begin
                if (!issued_q) begin
                    issued_d  = 1'b1;
                    arvalid_d = 1'b1;
                    araddr_d  = state_q == RD_STAT ? C_M_AXI_ADDR_WIDTH'(ADDR_CTRL) : C_M_AXI_ADDR_WIDTH'(ADDR_RXDATA);
                end else begin
                    arvalid_d = arvalid_q && !M_AXI_ARREADY;
                    rready_d  = !arvalid_d && !r_hs;
                    if (r_hs) begin
                        issued_d = 1'b0;
                        gap_d    = '0;
                        if (state_q == RD_DATA) begin
                            push    = 1'b1;
                            state_d = stop_now ? IDLE : RD_STAT;
                        end else begin
                            state_d = stop_now ? IDLE :
                                      (M_AXI_RDATA[STAT_DATA_READY] && !fifo_full) ? RD_DATA : POLL_WAIT;
                        end
                    end
                end
            end
        endcase
    end

    // sequencer and AXI output registers; reset drops every valid at once
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q   <= IDLE;
            issued_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            araddr_q  <= '0;
            stop_q    <= 1'b0;
            err_q     <= 1'b0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            issued_q  <= issued_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            araddr_q  <= araddr_d;
            stop_q    <= stop_d;
            err_q     <= err_d;
            gap_q     <= gap_d;
        end
    end

`ifdef UART_POLL_OVERRUN_CNT_EN
    logic [15:0] ovr_q, ovr_d;

    // count status reads reporting overrun, holding at all-ones
    always_comb begin
        ovr_d = (state_q == RD_STAT && r_hs && M_AXI_RDATA[STAT_OVERRUN] && ovr_q != 16'hFFFF) ? ovr_q + 16'd1 : ovr_q;
    end

    // overrun counter register
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) ovr_q <= '0;
        else ovr_q <= ovr_d;
    end

    assign overrun_cnt = ovr_q;
`else
    assign overrun_cnt = 16'd0;
`endif

    uart_poll_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (M_AXI_ACLK),
        .rst       (M_AXI_ARESET),
        .push      (push),
        .push_data (M_AXI_RDATA[DATA_WIDTH-1:0]),
        .pop       (rx_tvalid && rx_tready),
        .pop_data  (rx_tdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
